sobel_line_buffer: RTL

- Upstream neighbour of the Sobel multiply-accumulate core. Takes a raster pixel stream, one pixel per valid cycle.
- Presents three vertically aligned pixels per column: row n-2, row n-1 and row n.
- Outputs are 9-bit signed values with a data-enable, matching the core's three data inputs and DE input.
- Contains two line memories plus column/row tracking, so the core only sees valid 3-row columns.

---
 rtl/sobel_line_buffer_pkg.sv | 20 ++
 rtl/sobel_line_buffer_if.sv | 25 ++
 rtl/sobel_line_buffer_line_ram.sv | 38 +++
 rtl/sobel_line_buffer.sv | 102 ++++++++++
 4 files changed

// File: rtl/sobel_line_buffer_pkg.sv
// Shared constants and types for the Sobel pipeline: pixel/data widths,
// default line length and the 3x3 kernel coefficients.
package sobel_pkg;

  localparam int PIX_W         = 8;
  localparam int SOBEL_DATA_W  = 9;
  localparam int IMG_WIDTH_DEF = 640;
  localparam int COL_W_DEF     = 10;

  typedef logic signed [SOBEL_DATA_W-1:0] sobel_data_t;

  // Row-major 3x3 kernels; row 0 pairs with the oldest line (row n-2).
  localparam int GX [0:2][0:2] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int GY [0:2][0:2] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  function automatic sobel_data_t zext_pix(input logic [PIX_W-1:0] pix);
    return sobel_data_t'({1'b0, pix});
  endfunction

endpackage

// File: rtl/sobel_line_buffer_if.sv
// Pixel-stream input and three-row column output of the Sobel line buffer.
interface sobel_line_buffer_if #(
  parameter int PIX_W = sobel_pkg::PIX_W
);
  import sobel_pkg::*;

  logic [PIX_W-1:0]  InPixel;
  logic              InPixelDe;
  logic              InVsync;
  sobel_data_t       OutData1;
  sobel_data_t       OutData2;
  sobel_data_t       OutData3;
  logic              OutDataDe;

  modport master (
    output InPixel, InPixelDe, InVsync,
    input  OutData1, OutData2, OutData3, OutDataDe
  );

  modport slave (
    input  InPixel, InPixelDe, InVsync,
    output OutData1, OutData2, OutData3, OutDataDe
  );

endinterface

// File: rtl/sobel_line_buffer_line_ram.sv
// Simple dual-port line memory: one write port, one registered read port,
// read-during-write to the same address returns the previous contents.
module line_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the output register is reset; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sobel_line_buffer.sv
// Two-line buffer feeding the Sobel core with vertically aligned pixels of
// rows n-2, n-1 and n; data-enable only once two full lines are stored.
module sobel_line_buffer #(
  parameter int IMG_WIDTH = sobel_pkg::IMG_WIDTH_DEF,
  parameter int PIX_W     = sobel_pkg::PIX_W,
  parameter int COL_W     = sobel_pkg::COL_W_DEF
) (
  input  logic                InClk,
  input  logic                InRst,
  sobel_line_buffer_if.slave  bus
);
  import sobel_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0] col_reg, col_next, addr;
  logic [1:0]       row_reg, row_next, row_base;
  logic             accept;

  logic [PIX_W-1:0] a_rd, b_rd;
  logic [PIX_W-1:0] pix_reg, byp_data_reg;
  logic [COL_W-1:0] b_addr_reg;
  logic             b_we_reg, hit_reg, de_reg;

  assign accept = bus.InPixelDe && !InRst;

  // A vsync-qualified pixel is treated as row 0, column 0.
  always_comb begin
    addr     = bus.InVsync ? '0 : col_reg;
    row_base = bus.InVsync ? 2'd0 : row_reg;
    col_next = col_reg;
    row_next = row_reg;
    if (bus.InPixelDe) begin
      if (addr == LAST_COL) begin
        col_next = '0;
        row_next = (row_base == 2'd2) ? 2'd2 : 2'(row_base + 2'd1);
      end else begin
        col_next = addr + COL_W'(1);
        row_next = row_base;
      end
    end else if (bus.InVsync) begin
      col_next = '0;
      row_next = 2'd0;
    end
  end

  // lineA (row n-1) is written with the incoming pixel.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_line_a (
    .clk   (InClk),
    .srst  (InRst),
    .we    (accept),
    .waddr (addr),
    .wdata (bus.InPixel),
    .re    (accept),
    .raddr (addr),
    .rdata (a_rd)
  );

  // lineB (row n-2) takes lineA's old word one cycle later, once the
  // registered read has produced it; b_rd stays aligned with a_rd.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(COL_W)) u_line_b (
    .clk   (InClk),
    .srst  (InRst),
    .we    (b_we_reg),
    .waddr (b_addr_reg),
    .wdata (a_rd),
    .re    (accept),
    .raddr (addr),
    .rdata (b_rd)
  );

  always_ff @(posedge InClk) begin
    if (InRst) begin
      col_reg      <= '0;
      row_reg      <= 2'd0;
      pix_reg      <= '0;
      de_reg       <= 1'b0;
      b_we_reg     <= 1'b0;
      b_addr_reg   <= '0;
      hit_reg      <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      col_reg    <= col_next;
      row_reg    <= row_next;
      de_reg     <= bus.InPixelDe && (row_reg == 2'd2) && !bus.InVsync;
      b_we_reg   <= bus.InPixelDe;
      b_addr_reg <= addr;
      if (bus.InPixelDe) begin
        pix_reg      <= bus.InPixel;
        // Reading the column whose deferred lineB write lands this edge.
        hit_reg      <= b_we_reg && (b_addr_reg == addr);
        byp_data_reg <= a_rd;
      end
    end
  end

  assign bus.OutData3  = zext_pix(pix_reg);
  assign bus.OutData2  = zext_pix(a_rd);
  assign bus.OutData1  = zext_pix(hit_reg ? byp_data_reg : b_rd);
  assign bus.OutDataDe = de_reg;

endmodule
